// File: rtl/axil_gpio_ctrl.sv
// AXI4-Lite GPIO controller.
// Exposes N_GPIO bidirectional tristate pins through memory-mapped OUT and DIR
// registers and a synchronised IN register. The register map is decoded from
// the low address bits delivered by the interconnect. Every response is OKAY.
//
// Handshake semantics (both channels): a beat transfers on a rising edge where
// valid and ready are both high. Once the slave raises bvalid or rvalid, it
// holds that signal and its payload stable until the matching bready/rready is
// sampled high. The ready outputs are combinational from the request valids.
// AW and W are accepted only together, and only while no write response is
// pending. AR is accepted only while no read response is pending.

module axil_gpio_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int N_GPIO     = 64
) (
    input  logic                  clk,
    input  logic                  rstn,

    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,

    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,

    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,

    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,

    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready,

    inout  wire  [N_GPIO-1:0]     gpio
);

    // Word index of the register map: byte address bits [1:0] are ignored.
    localparam int IDX_W = ADDR_WIDTH - 2;

    localparam logic [IDX_W-1:0] REG_OUT_LO = IDX_W'(0);
    localparam logic [IDX_W-1:0] REG_OUT_HI = IDX_W'(1);
    localparam logic [IDX_W-1:0] REG_DIR_LO = IDX_W'(2);
    localparam logic [IDX_W-1:0] REG_DIR_HI = IDX_W'(3);
    localparam logic [IDX_W-1:0] REG_IN_LO  = IDX_W'(4);
    localparam logic [IDX_W-1:0] REG_IN_HI  = IDX_W'(5);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                  ready_en_q;   // low in reset and for the first cycle after
    logic [N_GPIO-1:0]     out_q;
    logic [N_GPIO-1:0]     dir_q;
    logic [N_GPIO-1:0]     sync1_q;
    logic [N_GPIO-1:0]     sync2_q;
    logic                  bvalid_q;
    logic                  rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]      waddr_idx;
    logic [IDX_W-1:0]      raddr_idx;
    logic                  wr_fire;
    logic                  rd_fire;
    logic [63:0]           out_ext;
    logic [63:0]           dir_ext;
    logic [63:0]           in_ext;
    logic [63:0]           out_nxt;
    logic [63:0]           dir_nxt;
    logic [DATA_WIDTH-1:0] rdata_nxt;

    // Protection bits and the byte offset within a word carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{s_axil_awprot, s_axil_arprot,
                           s_axil_awaddr[1:0], s_axil_araddr[1:0]};

    assign waddr_idx = s_axil_awaddr[ADDR_WIDTH-1:2];
    assign raddr_idx = s_axil_araddr[ADDR_WIDTH-1:2];

    // Registers are viewed as 64 bits wide; pins at index >= N_GPIO do not
    // exist, so their bits read as zero and writes to them are dropped when
    // the 64-bit next value is truncated back to N_GPIO.
    assign out_ext = 64'(out_q);
    assign dir_ext = 64'(dir_q);
    assign in_ext  = 64'(sync2_q);

    // Merge a write word into an existing 32-bit register half byte by byte.
    function automatic logic [31:0] apply_strb(
        input logic [31:0]           old_val,
        input logic [DATA_WIDTH-1:0] new_val,
        input logic [STRB_WIDTH-1:0] strb
    );
        logic [31:0] res;
        res = old_val;
        for (int k = 0; k < STRB_WIDTH; k++) begin
            if (strb[k]) begin
                res[k*8 +: 8] = new_val[k*8 +: 8];
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Handshake outputs
    // ------------------------------------------------------------------
    assign s_axil_awready = ready_en_q && s_axil_awvalid && s_axil_wvalid && !bvalid_q;
    assign s_axil_wready  = s_axil_awready;
    assign s_axil_arready = ready_en_q && s_axil_arvalid && !rvalid_q;

    assign wr_fire = s_axil_awready;
    assign rd_fire = s_axil_arready;

    assign s_axil_bvalid = bvalid_q;
    assign s_axil_bresp  = 2'b00;
    assign s_axil_rvalid = rvalid_q;
    assign s_axil_rdata  = rdata_q;
    assign s_axil_rresp  = 2'b00;

    // ------------------------------------------------------------------
    // Pin drive: a pin is driven only while its direction bit selects output.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < N_GPIO; i++) begin : g_pin
        assign gpio[i] = dir_q[i] ? out_q[i] : 1'bz;
    end

    // Hold the ready outputs low until the first clock after reset release.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
        end
    end

    // Next value of OUT/DIR for an accepted write; IN and unmapped offsets fall
    // through unchanged so such writes complete without side effects.
    always_comb begin
        out_nxt = out_ext;
        dir_nxt = dir_ext;
        if (wr_fire) begin
            case (waddr_idx)
                REG_OUT_LO: out_nxt[31:0]  = apply_strb(out_ext[31:0],  s_axil_wdata, s_axil_wstrb);
                REG_OUT_HI: out_nxt[63:32] = apply_strb(out_ext[63:32], s_axil_wdata, s_axil_wstrb);
                REG_DIR_LO: dir_nxt[31:0]  = apply_strb(dir_ext[31:0],  s_axil_wdata, s_axil_wstrb);
                REG_DIR_HI: dir_nxt[63:32] = apply_strb(dir_ext[63:32], s_axil_wdata, s_axil_wstrb);
                default: ;
            endcase
        end
    end

    // OUT and DIR register storage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_q <= '0;
            dir_q <= '0;
        end else begin
            out_q <= out_nxt[N_GPIO-1:0];
            dir_q <= dir_nxt[N_GPIO-1:0];
        end
    end

    // Write response: raised on the accept edge, dropped when bready is seen.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bvalid_q <= 1'b0;
        end else if (wr_fire) begin
            bvalid_q <= 1'b1;
        end else if (s_axil_bready) begin
            bvalid_q <= 1'b0;
        end
    end

    // Two-flop synchroniser on the pins; output pins read back their own level.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= gpio;
            sync2_q <= sync1_q;
        end
    end

    // Read mux: current register values, so a same-cycle write is not visible.
    always_comb begin
        rdata_nxt = '0;
        case (raddr_idx)
            REG_OUT_LO: rdata_nxt = out_ext[31:0];
            REG_OUT_HI: rdata_nxt = out_ext[63:32];
            REG_DIR_LO: rdata_nxt = dir_ext[31:0];
            REG_DIR_HI: rdata_nxt = dir_ext[63:32];
            REG_IN_LO:  rdata_nxt = in_ext[31:0];
            REG_IN_HI:  rdata_nxt = in_ext[63:32];
            default:    rdata_nxt = '0;
        endcase
    end

    // Read response: data captured on the accept edge and held until rready.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else if (rd_fire) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rdata_nxt;
        end else if (s_axil_rready) begin
            rvalid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axil_gpio_ctrl.sv
// Directed bench for axil_gpio_ctrl. A 64-pin instance carries most checks;
// a 40-pin instance shares the same request inputs so the partial-width
// register behaviour can be observed on the same transactions.

module tb_axil_gpio_ctrl;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Shared master signals
    // ------------------------------------------------------------------
    logic [11:0] awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;

    // 64-pin instance outputs
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    wire  [63:0] gpio0;

    // 40-pin instance outputs
    logic        awready1, wready1, bvalid1, arready1, rvalid1;
    logic [1:0]  bresp1, rresp1;
    logic [31:0] rdata1;
    wire  [39:0] gpio1;

    // Bench pin drivers (64-pin instance only)
    logic [63:0] tb_en;
    logic [63:0] tb_val;
    for (genvar i = 0; i < 64; i++) begin : g_drv
        assign gpio0[i] = tb_en[i] ? tb_val[i] : 1'bz;
    end

    axil_gpio_ctrl #(.N_GPIO(64)) dut (
        .clk(clk), .rstn(rstn),
        .s_axil_awaddr(awaddr), .s_axil_awprot(awprot),
        .s_axil_awvalid(awvalid), .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb),
        .s_axil_wvalid(wvalid), .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arprot(arprot),
        .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp),
        .s_axil_rvalid(rvalid), .s_axil_rready(rready),
        .gpio(gpio0)
    );

    axil_gpio_ctrl #(.N_GPIO(40)) dut40 (
        .clk(clk), .rstn(rstn),
        .s_axil_awaddr(awaddr), .s_axil_awprot(awprot),
        .s_axil_awvalid(awvalid), .s_axil_awready(awready1),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb),
        .s_axil_wvalid(wvalid), .s_axil_wready(wready1),
        .s_axil_bresp(bresp1), .s_axil_bvalid(bvalid1), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arprot(arprot),
        .s_axil_arvalid(arvalid), .s_axil_arready(arready1),
        .s_axil_rdata(rdata1), .s_axil_rresp(rresp1),
        .s_axil_rvalid(rvalid1), .s_axil_rready(rready),
        .gpio(gpio1)
    );

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver tasks: entered and left at a falling edge.
    // ------------------------------------------------------------------
    task automatic axi_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int n;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        #1;
        n = 0;
        while (!(awready && wready) && n < 50) begin
            @(negedge clk); #1; n++;
        end
        check("wr_accept", {63'd0, awready && wready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        check("wr_bvalid", {63'd0, bvalid}, 64'd1);
        check("wr_bresp", {62'd0, bresp}, 64'd0);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic axi_read(input logic [11:0] addr, output logic [31:0] d0,
                            output logic [31:0] d1, output logic [1:0] resp);
        int n;
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        #1;
        n = 0;
        while (!arready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        check("rd_accept", {63'd0, arready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        arvalid = 1'b0;
        check("rd_rvalid", {63'd0, rvalid}, 64'd1);
        d0 = rdata; d1 = rdata1; resp = rresp;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic read_check(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        logic [31:0] d0, d1;
        logic [1:0]  resp;
        exp_q.push_back({32'd0, exp});
        axi_read(addr, d0, d1, resp);
        check(tag, {32'd0, d0}, exp_q.pop_front());
        check({tag, "_rresp"}, {62'd0, resp}, 64'd0);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin : main
        logic [31:0] d0, d1;
        logic [1:0]  resp;
        int          ok;

        rstn = 1'b0;
        awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        bready = 1'b0; rready = 1'b0;
        wdata = '0; wstrb = '0;
        tb_en = '0; tb_val = '0;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state, even with requests pending.
        check("rst_ready", {61'd0, awready, wready, arready}, 64'd0);
        check("rst_valid", {62'd0, bvalid, rvalid}, 64'd0);
        check("rst_rdata", {32'd0, rdata}, 64'd0);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        rstn = 1'b1;
        @(negedge clk);

        // All pins are inputs after reset: the bench can drive every one.
        tb_en  = 64'hFFFF_FFFF_FFFF_FFFF;
        tb_val = 64'hCAFE_F00D_1234_5678;
        repeat (3) @(negedge clk);
        read_check("rst_out_lo", 12'h000, 32'h0000_0000);
        read_check("rst_dir_lo", 12'h008, 32'h0000_0000);
        read_check("in_lo_all_in", 12'h010, 32'h1234_5678);
        read_check("in_hi_all_in", 12'h014, 32'hCAFE_F00D);

        // Drive pins [7:0] from the block; bench keeps driving [63:8].
        tb_en = 64'hFFFF_FFFF_FFFF_FF00;
        axi_write(12'h008, 32'h0000_00FF, 4'hF);
        axi_write(12'h000, 32'hA5A5_A5A5, 4'hF);
        check("pin_drive_lo", {56'd0, gpio0[7:0]}, 64'hA5);
        repeat (2) @(negedge clk);
        read_check("in_lo_mixed", 12'h010, 32'h1234_56A5);
        read_check("dir_lo_rb", 12'h008, 32'h0000_00FF);

        // Pin change: a read accepted at once still sees the old level.
        tb_val[63:32] = 32'hDEAD_BEEF;
        read_check("in_hi_early", 12'h014, 32'hCAFE_F00D);
        read_check("in_hi_late", 12'h014, 32'hDEAD_BEEF);

        // Byte strobes.
        axi_write(12'h000, 32'h1111_1111, 4'hF);
        axi_write(12'h000, 32'h0000_3C00, 4'b0010);
        read_check("strb_out_lo", 12'h000, 32'h1111_3C11);
        check("pin_drive_strb", {56'd0, gpio0[7:0]}, 64'h11);
        axi_write(12'h004, 32'hFFFF_FFFF, 4'b1000);
        axi_read(12'h004, d0, d1, resp);
        check("strb_out_hi", {32'd0, d0}, 64'hFF00_0000);
        check("strb_out_hi_n40", {32'd0, d1}, 64'h0000_0000);

        // Write backpressure: second write waits behind a held response.
        awaddr = 12'h004; wdata = 32'hAAAA_0001; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        #1;
        check("bp_w_first", {63'd0, awready && wready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        wdata = 32'h5555_0002;
        #1;
        ok = 0;
        for (int i = 0; i < 5; i++) begin
            if (bvalid === 1'b1 && awready === 1'b0 && wready === 1'b0) ok++;
            @(negedge clk); #1;
        end
        check("bp_w_hold", 64'(ok), 64'd5);
        bready = 1'b1;
        #1;
        check("bp_w_blocked", {63'd0, awready}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("bp_w_second", {63'd0, awready && wready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        check("bp_w_bvalid2", {63'd0, bvalid}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        axi_read(12'h004, d0, d1, resp);
        check("bp_w_out_hi", {32'd0, d0}, 64'h5555_0002);
        check("bp_w_out_hi_n40", {32'd0, d1}, 64'h0000_0002);

        // Unimplemented bits above pin 39 on the 40-pin instance.
        axi_write(12'h004, 32'hFFFF_FFFF, 4'hF);
        axi_read(12'h004, d0, d1, resp);
        check("out_hi_full", {32'd0, d0}, 64'hFFFF_FFFF);
        check("out_hi_n40", {32'd0, d1}, 64'h0000_00FF);

        // Read backpressure: rdata held, second read waits.
        araddr = 12'h000; arvalid = 1'b1; rready = 1'b0;
        #1;
        check("bp_r_first", {63'd0, arready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        araddr = 12'h008;
        #1;
        ok = 0;
        for (int i = 0; i < 5; i++) begin
            if (rvalid === 1'b1 && arready === 1'b0 && rdata === 32'h1111_3C11) ok++;
            @(negedge clk); #1;
        end
        check("bp_r_hold", 64'(ok), 64'd5);
        rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("bp_r_second", {63'd0, arready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        arvalid = 1'b0;
        check("bp_r_rvalid2", {63'd0, rvalid}, 64'd1);
        check("bp_r_rdata2", {32'd0, rdata}, 64'h0000_00FF);
        @(posedge clk);
        @(negedge clk);

        // Unmapped and read-only offsets.
        axi_write(12'h020, 32'hFFFF_FFFF, 4'hF);
        axi_write(12'h010, 32'h0000_0000, 4'hF);
        read_check("unmapped_20", 12'h020, 32'h0000_0000);
        read_check("unmapped_ffc", 12'hFFC, 32'h0000_0000);
        read_check("in_lo_after_wr", 12'h010, 32'h1234_5611);
        read_check("out_lo_no_alias", 12'h000, 32'h1111_3C11);
        read_check("dir_lo_no_alias", 12'h008, 32'h0000_00FF);

        // Same-cycle read and write of OUT_LO: read sees the old value.
        fork
            axi_write(12'h000, 32'h0BAD_F00D, 4'hF);
            axi_read(12'h000, d0, d1, resp);
        join
        check("same_cycle_old", {32'd0, d0}, 64'h1111_3C11);
        read_check("same_cycle_new", 12'h000, 32'h0BAD_F00D);

        // Reset during a pending write response aborts it.
        awaddr = 12'h000; wdata = 32'h7777_7777; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_bvalid_pre", {63'd0, bvalid}, 64'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("mid_rst_bvalid_async", {63'd0, bvalid}, 64'd0);
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        ok = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bvalid === 1'b0) ok++;
        end
        check("mid_rst_no_resp", 64'(ok), 64'd3);
        bready = 1'b1;
        read_check("mid_rst_out_lo", 12'h000, 32'h0000_0000);
        read_check("mid_rst_dir_lo", 12'h008, 32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axil_gpio_ctrl.md
Name: axil_gpio_ctrl

Overview:
- AXI4-Lite slave exposing N_GPIO bidirectional tristate pins through memory-mapped output, direction and input registers.
- Sits on one master port of the system AXI-Lite interconnect (4 KB window, e.g. base 0x0400_1000).
- Interconnect delivers the low ADDR_WIDTH address bits; the block decodes them locally.

Parameters:
- DATA_WIDTH, 32, AXI-Lite data width; only 32 supported.
- ADDR_WIDTH, 12, AXI-Lite address width (4 KB window).
- STRB_WIDTH, DATA_WIDTH/8, write strobe width.
- N_GPIO, 64, pin count; legal range 1..64.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rstn  in  1  asynchronous active-low reset
- s_axil_awaddr  in  ADDR_WIDTH  write address
- s_axil_awprot  in  3  ignored
- s_axil_awvalid/s_axil_awready  in/out  1  write address handshake
- s_axil_wdata  in  DATA_WIDTH  write data
- s_axil_wstrb  in  STRB_WIDTH  byte enables
- s_axil_wvalid/s_axil_wready  in/out  1  write data handshake
- s_axil_bresp  out  2  always 2'b00 (OKAY)
- s_axil_bvalid/s_axil_bready  out/in  1  write response handshake
- s_axil_araddr  in  ADDR_WIDTH  read address
- s_axil_arprot  in  3  ignored
- s_axil_arvalid/s_axil_arready  in/out  1  read address handshake
- s_axil_rdata  out  DATA_WIDTH  read data
- s_axil_rresp  out  2  always 2'b00
- s_axil_rvalid/s_axil_rready  out/in  1  read data handshake
- gpio  inout  N_GPIO  pins

Behaviour:
- Register map (word offsets, decode addr[ADDR_WIDTH-1:2], addr[1:0] ignored):
  - 0x00 OUT_LO: out[31:0], RW
  - 0x04 OUT_HI: out[63:32], RW
  - 0x08 DIR_LO: dir[31:0], RW; 1 = output
  - 0x0C DIR_HI: dir[63:32], RW
  - 0x10 IN_LO: in[31:0], RO
  - 0x14 IN_HI: in[63:32], RO
- Bits at index ≥ N_GPIO: not implemented, read 0, writes discarded.
- Pin drive: gpio[i] = dir[i] ? out[i] : 1'bz.
- Input path: gpio sampled through a 2-flop synchronizer into in[]. IN reflects the pin 2 cycles after a change; output pins read back their driven level.
- Write channel:
  - awready and wready pulse together for 1 cycle when awvalid && wvalid && !bvalid.
  - Register is updated on that edge, per byte where wstrb[k]=1.
  - bvalid asserts the following cycle and holds until bready.
  - A new write is not accepted while bvalid=1.
  - AW without W, or W without AW: not accepted; block waits for both.
- Read channel:
  - arready pulses for 1 cycle when arvalid && !rvalid.
  - rdata is registered from the current register value on that edge; rvalid asserts the next cycle.
  - rdata and rvalid hold stable until rready.
- Latency: 1 cycle from accept to bvalid/rvalid. With ready tied high, one transaction per 2 cycles per channel.
- Read and write channels are independent and may complete in the same cycle. A same-cycle read of a register being written returns the pre-write value.
- Unmapped offsets (0x18..0xFFC): reads return 0 with OKAY; writes are ignored with OKAY. Writes to IN_LO/IN_HI are ignored with OKAY.
- Reset (rstn=0, asynchronous), all of the following cleared:
  - out = 0; dir = 0, so all pins high-Z; synchronizer flops = 0.
  - awready, wready, arready, bvalid, rvalid = 0; rdata = 0; bresp, rresp = 0.
- Reset asserted mid-transaction aborts it; no response is issued after release.

Test Plan:
- Reset, then read 0x00, 0x08, 0x10 → rdata 0, rresp 00; gpio all Z.
- Write DIR_LO=0x0000_00FF, OUT_LO=0xA5A5_A5A5 → gpio[7:0]=0xA5, gpio[31:8]=Z. After ≥2 cycles, read IN_LO → 0x0000_00A5 (bench leaves other pins Z and reads them as x/0 on masked bits).
- Bench drives gpio[63:32]=0xDEAD_BEEF with DIR_HI=0 → read IN_HI returns 0xDEAD_BEEF no earlier than 2 cycles after the pin change.
- Byte-strobe write: wstrb=4'b0010, wdata=0x0000_3C00 to OUT_LO (previously 0x1111_1111) → readback 0x1111_3C11.
- Backpressure: hold bready=0 for 5 cycles after a write → bvalid stays 1 and awready stays 0 for a second queued write; release bready → second write is accepted the next cycle. Same check for rready/rvalid.
- Unmapped/RO access: write 0x20 and IN_LO, read 0x20 → all OKAY, read 0, IN unaffected. With N_GPIO=40, write OUT_HI=0xFFFF_FFFF → readback 0x0000_00FF.
